// File: rtl/cic_decimator.sv
// cic_decimator: CIC decimation filter, ORDER integrators at input rate, ORDER combs at rate 1/R.
module cic_decimator #(
  parameter int IN_WIDTH   = 2,
  parameter int ORDER      = 3,
  parameter int DECIM_LOG2 = 4,
  parameter int OUT_WIDTH  = IN_WIDTH + ORDER*DECIM_LOG2
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_en,
  input  logic                        i_clr,
  input  logic signed [IN_WIDTH-1:0]  i_data,
  output logic signed [OUT_WIDTH-1:0] o_data,
  output logic                        o_valid
);
  typedef logic signed [OUT_WIDTH-1:0] word_t;
  word_t                 x_ext;
  word_t                 integ_q [ORDER];
  word_t                 stg_q   [ORDER+1];
  word_t                 dly_q   [ORDER];
  logic [DECIM_LOG2-1:0] cnt_q;
  logic                  dec_q;
  logic [ORDER:0]        vld_q;
  assign x_ext   = word_t'(i_data);
  assign o_data  = stg_q[ORDER];
  assign o_valid = vld_q[ORDER];
  // stg_q[0] is the decimated comb input; stg_q[k+1] is comb stage k output, valid with vld_q[k+1]
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      integ_q <= '{default: '0};
      stg_q   <= '{default: '0};
      dly_q   <= '{default: '0};
      cnt_q   <= '0;
      dec_q   <= 1'b0;
      vld_q   <= '0;
    end else if (i_clr) begin
      integ_q <= '{default: '0};
      stg_q   <= '{default: '0};
      dly_q   <= '{default: '0};
      cnt_q   <= '0;
      dec_q   <= 1'b0;
      vld_q   <= '0;
    end else begin
      if (i_en) begin
        integ_q[0] <= integ_q[0] + x_ext;
        for (int k = 1; k < ORDER; k++) integ_q[k] <= integ_q[k] + integ_q[k-1];
        cnt_q <= cnt_q + 1'b1;
      end
      dec_q <= i_en && (cnt_q == '1);
      if (dec_q) stg_q[0] <= integ_q[ORDER-1];
      for (int k = 0; k < ORDER; k++) begin
        if (vld_q[k]) begin
          stg_q[k+1] <= stg_q[k] - dly_q[k];
          dly_q[k]   <= stg_q[k];
        end
      end
      vld_q <= {vld_q[ORDER-1:0], dec_q};
    end
  end
endmodule

// File: doc/cic_decimator.md
CIC_DECIMATOR -- requirements
Module: cic_decimator

Interface
REQ-001 Parameter IN_WIDTH, default 2, signed modulator sample width (bitstream codes +1/-1; -2..+1 legal).
REQ-002 Parameter ORDER, default 3, number of integrator stages and number of comb stages (1..5).
REQ-003 Parameter DECIM_LOG2, default 4, log2 of decimation ratio R (R = 2**DECIM_LOG2).
REQ-004 Parameter OUT_WIDTH, default IN_WIDTH + ORDER*DECIM_LOG2, width of every internal register and of o_data.
REQ-005 i_clk  input  1  sole clock, all state on rising edge.
REQ-006 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 i_en  input  1  input sample valid, one sample per high cycle.
REQ-008 i_clr  input  1  synchronous flush of all state.
REQ-009 i_data  input  IN_WIDTH  signed modulator sample, sampled only when i_en=1.
REQ-010 o_data  output  OUT_WIDTH  signed decimated sample, registered.
REQ-011 o_valid  output  1  one-cycle strobe, o_data valid in that cycle.

Function
REQ-012 i_data SHALL be sign-extended to OUT_WIDTH before the first integrator.
REQ-013 All additions and subtractions SHALL be two's-complement modulo 2**OUT_WIDTH, no saturation, no overflow flag.
REQ-014 Integrator chain, on a cycle with i_en=1: stage1 <= stage1 + ext(i_data); stage k <= stage k + registered stage k-1 (pre-edge value), k=2..ORDER.
REQ-015 With i_en=0, integrators and decimation counter SHALL hold.
REQ-016 Decimation counter, DECIM_LOG2 bits, SHALL increment on each i_en=1 cycle and wrap from R-1 to 0.
REQ-017 An i_en=1 cycle with counter = R-1 SHALL set a decimation strobe in the following cycle, registering the updated last-integrator value as the comb input.
REQ-018 Comb chain: ORDER registered stages; stage k on its strobe: out_k <= in_k - dly_k, dly_k <= in_k; strobe shifts one stage per cycle.
REQ-019 Comb stages SHALL advance on strobes only, independent of i_en; in-flight frames SHALL complete even if i_en drops.
REQ-020 Latency: o_valid SHALL be high for exactly one cycle, ORDER+1 rising edges after the edge that accepts the R-th sample of a frame.
REQ-021 o_data SHALL hold its last value between strobes.
REQ-022 Output rate: exactly one o_valid per R accepted samples; back-to-back frames with i_en held high SHALL produce o_valid every R cycles.
REQ-023 DC gain SHALL be R**ORDER: constant input x yields settled o_data = x*R**ORDER (default x=+1 -> 4096, x=-2 -> -8192).
REQ-024 i_clr=1 SHALL, at the next edge, zero integrators, comb registers, delay registers, counter, strobe pipeline, o_data, o_valid; i_clr overrides a simultaneous i_en.
REQ-025 Sample presented with i_en=1 in the same cycle as i_clr=1 SHALL be discarded.

Reset
REQ-026 i_rst_n=0 SHALL asynchronously clear all registers: o_data=0, o_valid=0, counter=0, integrators, combs, delays, strobe pipeline=0.
REQ-027 Reset asserted mid-frame or with a strobe in flight SHALL discard the partial frame and pending output; no o_valid until R new samples after release.
REQ-028 First i_en after reset release SHALL be accepted as sample 0 of a new frame.

Verification
REQ-029 Defaults, i_en=1 continuous, i_data=+1 -> o_valid every 16 cycles, first at 4 edges after 16th sample edge; 5th and later outputs = 4096.
REQ-030 i_data alternating +1/-1, i_en=1 continuous -> 5th and later outputs = 0.
REQ-031 i_data=-2 constant -> settled outputs = -8192 (full-scale negative, no wrap error).
REQ-032 i_en toggling 1/0 each cycle, i_data=+1 -> o_valid every 32 cycles, settled value 4096; strobe completes through an i_en=0 gap.
REQ-033 i_rst_n pulsed low at sample 10 of a frame (and separately during comb flight) -> outputs zero immediately, no stale o_valid, next o_valid 4 edges after the 16th post-release sample.
REQ-034 i_clr with i_en=1 at counter=R-1 -> no o_valid for that frame, counter=0, sample dropped; subsequent behaviour identical to post-reset.
